// File: rtl/rib_mem_slave.sv
// RIB data-memory responder: word-addressed RAM behind the core's read/write request pins.
// Latency: request seen in IDLE at cycle T is answered in RESP at T+1+WAIT_CYCLES.
// Backpressure: rib_hold_flag_o stalls the core until the final RESP cycle of each access.
module rib_mem_slave #(
  parameter int          DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_rib_rreq_i,
  input  logic [31:0] mem_raddr_i,
  input  logic        mem_rib_wreq_i,
  input  logic        mem_wen_i,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        rib_hold_flag_o,
  output logic        err_o
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] WC_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_wr_q, is_wr_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        pend_q, pend_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          go_resp;
  logic          valid;
  logic [29:0]   off_w;
  logic [IW-1:0] idx;
  logic          ram_we;

  // Next-state logic; the access being answered is always described by the *_d
  // capture values, so the RAM port and decode work from the same source whether
  // RESP is entered from IDLE, WAIT or a RESP that chains into a pending read.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pend_d  = pend_q;
    paddr_d = paddr_q;
    go_resp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_rib_rreq_i || mem_rib_wreq_i) begin
          // A simultaneous read is parked behind the write so it sees the new data.
          is_wr_d = mem_rib_wreq_i;
          addr_d  = mem_rib_wreq_i ? mem_waddr_i : mem_raddr_i;
          wdata_d = mem_wdata_i;
          wen_d   = mem_rib_wreq_i & mem_wen_i;
          pend_d  = mem_rib_wreq_i & mem_rib_rreq_i;
          paddr_d = mem_raddr_i;
          cnt_d   = 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == WC_LAST) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (pend_q) begin
          is_wr_d = 1'b0;
          wen_d   = 1'b0;
          addr_d  = paddr_q;
          pend_d  = 1'b0;
          cnt_d   = 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address decode of the access about to be answered; BASE_ADDR is word aligned,
  // so the word offset can be taken on bits [31:2] alone.
  always_comb begin
    off_w  = addr_d[31:2] - BASE_ADDR[31:2];
    idx    = off_w[IW-1:0];
    valid  = (addr_d >= BASE_ADDR) && (off_w[29:IW] == '0) && (addr_d[1:0] == 2'b00);
    ram_we = rst_n_i & go_resp & is_wr_d & wen_d & valid;
  end

  // Response outputs are loaded on the edge entering RESP; rdata only moves on reads.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (go_resp) begin
      err_d = ~valid;
      if (!is_wr_d) begin
        rdata_d = valid ? mem[idx] : 32'h0;
      end
    end
  end

  // Control and response registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      is_wr_q <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      pend_q  <= 1'b0;
      paddr_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pend_q  <= pend_d;
      paddr_q <= paddr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      mem[idx] <= wdata_d;
    end
  end

  // Hold drops in the final RESP so the core advances exactly when data is ready.
  always_comb begin
    rib_hold_flag_o = rst_n_i &
                      (((state_q == ST_IDLE) && (mem_rib_rreq_i || mem_rib_wreq_i)) ||
                       (state_q == ST_WAIT) ||
                       ((state_q == ST_RESP) && pend_q));
  end

  assign mem_rdata_o = rdata_q;
  assign err_o       = err_q;

endmodule
